adsr_envelope: RTL and testbench

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/adsr_envelope.sv | 151 +++++++++++++++
 tb/tb_adsr_envelope.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope, advanced once per audio sample strobe.
// Define ADSR_EXP_RELEASE_EN for exponential release; default build is linear release.
module adsr_envelope #(
  parameter int unsigned ENV_W      = 16,
  parameter int unsigned STEP_SHIFT = 4
) (
  input  logic             iCLK_18_4,
  input  logic             iRST_N,
  input  logic             iSAMPLE_EN,
  input  logic             iGATE,
  input  logic [7:0]       iATTACK_STEP,
  input  logic [7:0]       iDECAY_STEP,
  input  logic [7:0]       iSUSTAIN_LVL,
  input  logic [7:0]       iRELEASE_STEP,
  output logic [ENV_W-1:0] oENV,
  output logic [2:0]       oSTATE,
  output logic             oACTIVE
);

  // Arithmetic runs one bit wider than any operand so saturation is a plain compare.
  localparam int unsigned RATE_W = 8 + STEP_SHIFT;
  localparam int unsigned MAX_W  = (ENV_W > RATE_W) ? ENV_W : RATE_W;
  localparam int unsigned AW     = ((MAX_W > 16) ? MAX_W : 16) + 1;
  localparam logic [AW-1:0] FULL = {{(AW-ENV_W){1'b0}}, {ENV_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ENV_W-1:0] env_q;
  logic [AW-1:0]   env_d;
  logic            active_q;
  logic            gate_meta;
  logic            gate_sync;

  logic [AW-1:0]   env_x;
  logic [AW-1:0]   d_att;
  logic [AW-1:0]   d_dec;
  logic [AW-1:0]   d_rel;
  logic [AW-1:0]   tgt_raw;
  logic [AW-1:0]   tgt;
  logic [AW-1:0]   att_sum;

  // Two-flop synchronizer for the asynchronous key gate.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      gate_meta <= 1'b0;
      gate_sync <= 1'b0;
    end else begin
      gate_meta <= iGATE;
      gate_sync <= gate_meta;
    end
  end

  assign env_x   = AW'(env_q);
  assign d_att   = AW'(iATTACK_STEP) << STEP_SHIFT;
  assign d_dec   = AW'(iDECAY_STEP) << STEP_SHIFT;
  assign tgt_raw = AW'({iSUSTAIN_LVL, 8'h00});
  assign tgt     = (tgt_raw > FULL) ? FULL : tgt_raw;
  assign att_sum = env_x + d_att;

`ifdef ADSR_EXP_RELEASE_EN
  logic unused_rel_hi;
  assign unused_rel_hi = ^iRELEASE_STEP[7:4];
  assign d_rel = (env_x >> iRELEASE_STEP[3:0]) + AW'(1);
`else
  // A zero rate means drop straight to silence.
  assign d_rel = (iRELEASE_STEP == 8'd0) ? FULL : (AW'(iRELEASE_STEP) << STEP_SHIFT);
`endif

  // Next state and envelope; everything holds between sample strobes.
  always_comb begin
    state_d = state_q;
    env_d   = env_x;
    if (iSAMPLE_EN) begin
      case (state_q)
        IDLE: begin
          if (gate_sync) state_d = ATTACK;
        end
        ATTACK: begin
          if (!gate_sync) begin
            state_d = RELEASE;
          end else if ((iATTACK_STEP == 8'd0) || (att_sum >= FULL)) begin
            env_d   = FULL;
            state_d = DECAY;
          end else begin
            env_d = att_sum;
          end
        end
        DECAY: begin
          if (!gate_sync) begin
            state_d = RELEASE;
          end else if ((iDECAY_STEP == 8'd0) || (env_x <= tgt) || ((env_x - tgt) <= d_dec)) begin
            env_d   = tgt;
            state_d = SUSTAIN;
          end else begin
            env_d = env_x - d_dec;
          end
        end
        SUSTAIN: begin
          if (!gate_sync) begin
            state_d = RELEASE;
          end else begin
            env_d = tgt;
          end
        end
        RELEASE: begin
          // Retrigger resumes attack from the current level to avoid a click.
          if (gate_sync) begin
            state_d = ATTACK;
          end else if (env_x <= d_rel) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_x - d_rel;
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  logic unused_env_hi;
  assign unused_env_hi = |env_d[AW-1:ENV_W];

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d[ENV_W-1:0];
      active_q <= (state_d != IDLE);
    end
  end

  assign oENV    = env_q;
  assign oSTATE  = state_q;
  assign oACTIVE = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized bench for adsr_envelope against a behavioural envelope model.
// Build with ADSR_EXP_RELEASE_EN defined to check the exponential release variant.
module tb_adsr_envelope;

  localparam longint FULL_SCALE = 64'd65535;
  localparam int P_IDLE = 0, P_ATTACK = 1, P_DECAY = 2, P_SUSTAIN = 3, P_RELEASE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic        gate;
  logic [7:0]  atk, dec, sus, rel;
  logic [15:0] env;
  logic [2:0]  state;
  logic        active;

  int     total = 0;
  int     bad = 0;
  int     strobe_period = 3;
  int     scnt = 0;

  // Reference model: phase, level and the two-clock gate delay.
  int     m_phase = P_IDLE;
  longint m_env = 0;
  bit     m_g1 = 1'b0;
  bit     m_gs = 1'b0;

  adsr_envelope dut (
    .iCLK_18_4    (clk),
    .iRST_N       (rst_n),
    .iSAMPLE_EN   (sample_en),
    .iGATE        (gate),
    .iATTACK_STEP (atk),
    .iDECAY_STEP  (dec),
    .iSUSTAIN_LVL (sus),
    .iRELEASE_STEP(rel),
    .oENV         (env),
    .oSTATE       (state),
    .oACTIVE      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_env   = 0;
    m_g1    = 1'b0;
    m_gs    = 1'b0;
  endtask

  // One clock of the model; the level only moves on a strobe.
  task automatic model_step();
    longint target;
    longint drop;
    target = longint'(sus) * 256;
    if (sample_en) begin
      if (m_phase == P_IDLE) begin
        if (m_gs) m_phase = P_ATTACK;
      end else if (m_phase != P_RELEASE && !m_gs) begin
        m_phase = P_RELEASE;
      end else if (m_phase == P_ATTACK) begin
        if (atk == 0 || m_env + longint'(atk) * 16 >= FULL_SCALE) begin
          m_env   = FULL_SCALE;
          m_phase = P_DECAY;
        end else begin
          m_env = m_env + longint'(atk) * 16;
        end
      end else if (m_phase == P_DECAY) begin
        if (dec == 0 || m_env - longint'(dec) * 16 <= target) begin
          m_env   = target;
          m_phase = P_SUSTAIN;
        end else begin
          m_env = m_env - longint'(dec) * 16;
        end
      end else if (m_phase == P_SUSTAIN) begin
        m_env = target;
      end else begin
        if (m_gs) begin
          m_phase = P_ATTACK;
        end else begin
`ifdef ADSR_EXP_RELEASE_EN
          drop = (m_env >> rel[3:0]) + 1;
`else
          drop = (rel == 0) ? m_env : longint'(rel) * 16;
`endif
          m_env = (m_env > drop) ? m_env - drop : 0;
          if (m_env == 0) m_phase = P_IDLE;
        end
      end
    end
    m_gs = m_g1;
    m_g1 = gate;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      if (strobe_period == 0) begin
        sample_en = ($urandom_range(0, 2) == 0);
      end else begin
        scnt      = (scnt + 1) % strobe_period;
        sample_en = (scnt == 0);
      end
      @(negedge clk);
      check("env", longint'(env), m_env);
      check("state", longint'(state), longint'(m_phase));
      check("active", longint'(active), longint'(m_phase != P_IDLE));
    end
  endtask

  initial begin
    longint e0;
    longint rel_first;
    rst_n     = 1'b0;
    gate      = 1'b0;
    sample_en = 1'b0;
    atk       = 8'h10;
    dec       = 8'h20;
    sus       = 8'h80;
`ifdef ADSR_EXP_RELEASE_EN
    rel       = 8'h04;
    rel_first = 64'h77FF;
`else
    rel       = 8'h40;
    rel_first = 64'h7C00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_env", longint'(env), 0);
    check("rst_state", longint'(state), P_IDLE);
    check("rst_active", longint'(active), 0);
    #2 rst_n = 1'b1;

    // Full note with fixed rates.
    gate = 1'b1;
    for (int i = 0; i < 2000 && m_phase != P_DECAY; i++) run(1);
    check("peak_env", longint'(env), 64'hFFFF);
    check("peak_state", longint'(state), P_DECAY);
    for (int i = 0; i < 1000 && m_phase != P_SUSTAIN; i++) run(1);
    check("sus_env", longint'(env), 64'h8000);
    check("sus_state", longint'(state), P_SUSTAIN);
    run(30);
    check("sus_hold", longint'(env), 64'h8000);

    gate = 1'b0;
    for (int i = 0; i < 100 && m_env == 64'h8000; i++) run(1);
    check("rel_first", longint'(env), rel_first);
    for (int i = 0; i < 1000 && m_env > 64'h4000; i++) run(1);
    gate = 1'b1;
    for (int i = 0; i < 50 && m_phase != P_ATTACK; i++) run(1);
    check("retrig_state", longint'(state), P_ATTACK);
    e0 = m_env;
    check("retrig_level", longint'(env > 16'h3000), 1);
    run(12);
    check("retrig_rise", longint'(longint'(env) > e0), 1);

    gate = 1'b0;
    for (int i = 0; i < 3000 && m_phase != P_IDLE; i++) run(1);
    check("end_env", longint'(env), 0);
    check("end_state", longint'(state), P_IDLE);
    check("end_active", longint'(active), 0);

    // Asynchronous reset in the middle of decay, gate still held.
    gate = 1'b1;
    for (int i = 0; i < 2000 && m_phase != P_DECAY; i++) run(1);
    run(6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_env", longint'(env), 0);
    check("mid_rst_state", longint'(state), P_IDLE);
    check("mid_rst_active", longint'(active), 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 50 && m_phase != P_ATTACK; i++) run(1);
    check("restart_state", longint'(state), P_ATTACK);
    run(30);
    gate = 1'b0;
    run(400);

    // Random notes, rates and strobe spacing.
    strobe_period = 0;
    for (int n = 0; n < 20; n++) begin
      atk = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(16, 255));
      dec = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(16, 255));
      sus = 8'($urandom_range(0, 255));
`ifdef ADSR_EXP_RELEASE_EN
      rel = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 6))};
`else
      rel = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(16, 255));
`endif
      if ($urandom_range(0, 4) == 0) begin
        gate = 1'b1;
        run($urandom_range(1, 3));
        gate = 1'b0;
        run($urandom_range(5, 40));
      end
      gate = 1'b1;
      run($urandom_range(40, 600));
      sus = 8'($urandom_range(0, 255));
      run($urandom_range(20, 600));
      gate = 1'b0;
      run($urandom_range(20, 900));
    end
    gate = 1'b0;
    run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
